spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL expose parameter SYNC_STAGES, default 2: synchronizer depth on each SPI input.
REQ-002 SHALL expose parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk and rst_n.
REQ-004 clk  input  1  system clock, the only clock in the block.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-007 copi  input  1  SPI controller-out data, asynchronous to clk.
REQ-008 ncs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-009 en_reg_out_7_0  output  8  register at address 0x00.
REQ-010 en_reg_out_15_8  output  8  register at address 0x01.
REQ-011 en_reg_pwm_7_0  output  8  register at address 0x02.
REQ-012 en_reg_pwm_15_8  output  8  register at address 0x03.
REQ-013 pwm_duty_cycle  output  8  register at address 0x04; feeds the downstream PWM stage.

Function
REQ-014 Each of sclk, copi, ncs SHALL pass through a SYNC_STAGES-flop synchronizer on clk before any use.
REQ-015 Edge detect SHALL use one additional registered copy of synchronized sclk and ncs.
REQ-016 SPI mode 0 only: copi SHALL be sampled on a detected sclk rising edge while synchronized ncs is low.
REQ-017 Frame SHALL be 16 bits, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-018 A detected ncs falling edge SHALL clear the 16-bit shift register and the bit counter (state IDLE -> SHIFT).
REQ-019 Bit counter SHALL be 5 bits, increment per sampled bit, saturate at 17.
REQ-020 A detected ncs rising edge SHALL end the frame (SHIFT -> COMMIT -> IDLE).
REQ-021 COMMIT SHALL write data to the addressed register only if counter == 16, bit15 == 1, and address <= MAX_ADDR.
REQ-022 Frames with counter != 16, bit15 == 0, or address > MAX_ADDR SHALL be discarded with no register change.
REQ-023 Read frames SHALL cause no output activity; the block has no cipo.
REQ-024 A written register SHALL take its new value on the (SYNC_STAGES+2)th rising clk edge after ncs rises, i.e. 4 cycles by default.
REQ-025 sclk edges while ncs is high SHALL be ignored.
REQ-026 If an sclk rise and an ncs rise are detected in the same cycle, the ncs rise SHALL take precedence and the bit SHALL not be counted.
REQ-027 A new ncs falling edge while in SHIFT SHALL restart the frame and drop the partial one.
REQ-028 Correct operation SHALL be guaranteed for sclk frequency <= clk/4 and ncs high time >= 4 clk cycles.
REQ-029 Registers not addressed SHALL hold their values indefinitely.

Reset
REQ-030 While rst_n is low, all five outputs, the shift register, the counter and edge-detect flops SHALL be 0, and the state SHALL be IDLE.
REQ-031 Reset SHALL take effect immediately, without a clk edge.
REQ-032 Synchronizer flops SHALL reset so that ncs reads 1 and sclk reads 0, so no spurious edge is detected after reset.
REQ-033 Assertion mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh ncs falling edge.

Verification
REQ-034 Write 0x80 0xFF (addr 0x00, data 0xFF), clk 10 MHz, sclk 100 kHz -> en_reg_out_7_0 = 0xFF 4 clk after ncs rises; all other outputs stay 0.
REQ-035 Write 0x84 0x80 -> pwm_duty_cycle = 0x80; then read frame 0x04 0x00 -> pwm_duty_cycle stays 0x80.
REQ-036 Write 0x85 0x55 (addr 0x05, out of range) -> all outputs unchanged.
REQ-037 15-bit frame 0x82 0x7F minus last bit, then 17-bit frame -> no change to en_reg_pwm_7_0.
REQ-038 Write 0x83 0xAA; start 0x81, assert rst_n low after 8 bits, release, send full 0x81 0x3C -> en_reg_pwm_15_8 = 0x00 and en_reg_out_15_8 = 0x3C.
REQ-039 Back-to-back writes to 0x00-0x04 with the minimum ncs high time of 4 clk cycles -> all five registers hold the written values.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register peripheral.
// Receives 16-bit frames {R/W, addr[6:0], data[7:0]} MSB first and commits
// valid writes into five 8-bit control registers. All SPI inputs are
// resynchronised into the clk domain. Edges are found on the synchronised copies.
module spi_peripheral #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);

   localparam int NUM_REGS = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Synchroniser chains. ncs idles high and sclk idles low, so the chains
   // reset to those levels. A release from reset then does not look like an edge.
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] copi_sync;
   logic [SYNC_STAGES-1:0] ncs_sync;

   logic sclk_s;
   logic copi_s;
   logic ncs_s;

   // One extra registered copy of sclk and ncs, used for edge detection.
   logic sclk_prev;
   logic ncs_prev;

   logic sclk_rise;
   logic ncs_fall;
   logic ncs_rise;

   state_t      state_reg;
   state_t      state_next;
   logic [15:0] shift_reg;
   logic [15:0] shift_next;
   logic [4:0]  count_reg;
   logic [4:0]  count_next;
   logic        commit_en;
   logic        frame_ok;

   logic [6:0]  frame_addr;
   logic [7:0]  frame_data;

   logic [7:0]  regs [0:NUM_REGS-1];

   // Shift each asynchronous SPI input through its synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
      end else begin
         sclk_sync[0] <= sclk;
         copi_sync[0] <= copi;
         ncs_sync[0]  <= ncs;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync[i] <= sclk_sync[i-1];
            copi_sync[i] <= copi_sync[i-1];
            ncs_sync[i]  <= ncs_sync[i-1];
         end
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign copi_s = copi_sync[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync[SYNC_STAGES-1];

   // Keep the previous synchronised sclk/ncs levels so edges can be detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_prev <= 1'b0;
         ncs_prev  <= 1'b0;
      end else begin
         sclk_prev <= sclk_s;
         ncs_prev  <= ncs_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign ncs_fall  = ~ncs_s & ncs_prev;
   // ncs_prev resets low, so a one-cycle "rise" appears right after reset.
   // Only SHIFT acts on a rise, and the state machine is IDLE after reset.
   // That pulse is therefore harmless.
   assign ncs_rise  = ncs_s & ~ncs_prev;

   assign frame_addr = shift_reg[14:8];
   assign frame_data = shift_reg[7:0];

   // A frame is committed only if it has exactly 16 bits, is a write, and
   // targets an address in range.
   assign frame_ok = (count_reg == 5'd16) && shift_reg[15] &&
                     (frame_addr <= MAX_ADDR);

   // Register the frame state, the shift register and the bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         count_reg <= count_next;
      end
   end

   // Frame sequencing. A chip-select rise ends the frame and beats a
   // coincident sclk rise. A chip-select fall always restarts the frame.
   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      count_next = count_reg;
      commit_en  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ncs_fall) begin
               state_next = SHIFT;
               shift_next = '0;
               count_next = '0;
            end
         end
         SHIFT: begin
            if (ncs_fall) begin
               shift_next = '0;
               count_next = '0;
            end else if (ncs_rise) begin
               state_next = COMMIT;
            end else if (sclk_rise && !ncs_s) begin
               shift_next = {shift_reg[14:0], copi_s};
               if (count_reg != 5'd17) begin
                  count_next = count_reg + 5'd1;
               end
            end
         end
         COMMIT: begin
            commit_en = frame_ok;
            if (ncs_fall) begin
               state_next = SHIFT;
               shift_next = '0;
               count_next = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Register file: load the addressed register on a valid commit.
   // All other registers keep their values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (commit_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == 7'(i)) begin
               regs[i] <= frame_data;
            end
         end
      end
   end

   assign en_reg_out_7_0  = regs[0];
   assign en_reg_out_15_8 = regs[1];
   assign en_reg_pwm_7_0  = regs[2];
   assign en_reg_pwm_15_8 = regs[3];
   assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: reset state, write latency, read and
// out-of-range discard, short and long frames, mid-frame reset and
// back-to-back writes at minimum chip-select high time.
module tb_spi_peripheral;

   logic       clk;
   logic       rst_n;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;

   int errors = 0;
   int checks = 0;

   // Outputs packed as {pwm_duty, pwm_15_8, pwm_7_0, out_15_8, out_7_0}.
   logic [39:0] all_regs;
   assign all_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                      en_reg_out_15_8, en_reg_out_7_0};

   spi_peripheral #(
      .SYNC_STAGES (2),
      .MAX_ADDR    (7'h04)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clock out nbits of bits, MSB first, in mode 0 with the chip select already low.
   task automatic shift_bits(input logic [31:0] bits, input int nbits, input int half);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = bits[i];
         wait_clk(half);
         sclk = 1'b1;
         wait_clk(half);
         sclk = 1'b0;
      end
   endtask

   // Run a complete frame. ncs is left high just after a clk edge.
   task automatic spi_frame(input logic [31:0] bits, input int nbits, input int half);
      ncs = 1'b0;
      wait_clk(half);
      shift_bits(bits, nbits, half);
      wait_clk(half);
      ncs = 1'b1;
   endtask

   initial begin
      sclk  = 1'b0;
      copi  = 1'b0;
      ncs   = 1'b1;
      rst_n = 1'b0;
      wait_clk(3);
      check("reset_all_zero", all_regs, 40'h0);
      rst_n = 1'b1;
      wait_clk(5);
      check("post_reset_idle", all_regs, 40'h0);

      // Write 0x80 0xFF at a slow sclk. The update lands on the 4th clk edge after ncs rises.
      spi_frame(32'h80FF, 16, 50);
      wait_clk(3);
      check("latency_edge3_old", all_regs, 40'h00_00_00_00_00);
      wait_clk(1);
      check("latency_edge4_new", all_regs, 40'h00_00_00_00_FF);
      wait_clk(4);

      // Write the pwm duty cycle, then issue a read of the same address.
      spi_frame(32'h8480, 16, 4);
      wait_clk(8);
      check("write_pwm_duty", all_regs, 40'h80_00_00_00_FF);
      spi_frame(32'h0400, 16, 4);
      wait_clk(8);
      check("read_no_change", all_regs, 40'h80_00_00_00_FF);

      // Address 0x05 is above MAX_ADDR.
      spi_frame(32'h8555, 16, 4);
      wait_clk(8);
      check("addr_out_of_range", all_regs, 40'h80_00_00_00_FF);

      // 15-bit frame (0x827F minus its last bit), then a 17-bit frame.
      spi_frame(32'h413F, 15, 4);
      wait_clk(8);
      check("short_frame_15", all_regs, 40'h80_00_00_00_FF);
      spi_frame(32'h104FF, 17, 4);
      wait_clk(8);
      check("long_frame_17", all_regs, 40'h80_00_00_00_FF);

      // sclk toggling with ncs high must be ignored.
      shift_bits(32'h82AA, 16, 4);
      wait_clk(8);
      check("sclk_while_ncs_high", all_regs, 40'h80_00_00_00_FF);

      // Write 0x83 0xAA, then reset in the middle of a frame.
      spi_frame(32'h83AA, 16, 4);
      wait_clk(8);
      check("write_pwm_15_8", all_regs, 40'h80_AA_00_00_FF);
      ncs = 1'b0;
      wait_clk(4);
      shift_bits(32'h81, 8, 4);
      rst_n = 1'b0;
      #2;
      check("async_reset_no_edge", all_regs, 40'h0);
      wait_clk(3);
      rst_n = 1'b1;
      shift_bits(32'h3C, 8, 4);
      wait_clk(4);
      ncs = 1'b1;
      wait_clk(8);
      check("aborted_frame_dropped", all_regs, 40'h0);
      spi_frame(32'h813C, 16, 4);
      wait_clk(8);
      check("after_reset_write", all_regs, 40'h00_00_00_3C_00);

      // Back-to-back writes, 4-cycle ncs high time, sclk at clk/4.
      spi_frame(32'h8011, 16, 2);
      wait_clk(4);
      spi_frame(32'h8122, 16, 2);
      wait_clk(4);
      spi_frame(32'h8233, 16, 2);
      wait_clk(4);
      spi_frame(32'h8344, 16, 2);
      wait_clk(4);
      spi_frame(32'h8455, 16, 2);
      wait_clk(8);
      check("back_to_back_all", all_regs, 40'h55_44_33_22_11);

      // Idle for a while and confirm the registers hold.
      wait_clk(200);
      check("hold_values", all_regs, 40'h55_44_33_22_11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
